sound_arbiter: RTL

- Scheduler that shares the single tone generator (octave/note/length in, level enable, `over` back) between three requesters: live key hits, song autoplay and record playback.
- Selects one request per tone, drives the generator's operand registers and enable, tracks the tone through to `over`, and returns a one-cycle done pulse to the winner.
- Sits between the steady-mode input/song/record logic and the tone generator. It replaces the ad-hoc enable ORing with one arbitrated path.

---
 rtl/sound_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sound_arbiter.sv
// Arbitrates the single tone generator between live keys, record playback and song
// autoplay; tracks each granted tone to completion, preemption or ack timeout.
module sound_arbiter #(
  parameter int OCT_W       = 3,
  parameter int NOTE_W      = 3,
  parameter int LEN_W       = 3,
  parameter int ACK_TIMEOUT = 1023,
  parameter int PREEMPT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    req,
  input  logic [OCT_W+NOTE_W+LEN_W-1:0] live_op,
  input  logic [OCT_W+NOTE_W+LEN_W-1:0] rec_op,
  input  logic [OCT_W+NOTE_W+LEN_W-1:0] song_op,
  input  logic                          snd_over,
  output logic                          snd_en,
  output logic [OCT_W-1:0]              snd_octave,
  output logic [NOTE_W-1:0]             snd_note,
  output logic [LEN_W-1:0]              snd_length,
  output logic [2:0]                    grant,
  output logic [2:0]                    done,
  output logic [2:0]                    aborted,
  output logic                          timeout_err
);

  localparam int OP_W  = OCT_W + NOTE_W + LEN_W;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, PLAY, DONE, ABORT} state_t;

  state_t           state;
  logic [CNT_W-1:0] ack_cnt;
  logic [OP_W-1:0]  win_op;
  logic [2:0]       winner;
  logic             preempt;

  // Fixed priority: live > record > song.
  function automatic logic [2:0] pick_winner(input logic [2:0] r);
    if (r[0])      return 3'b001;
    else if (r[1]) return 3'b010;
    else if (r[2]) return 3'b100;
    else           return 3'b000;
  endfunction

  always_comb begin
    winner = pick_winner(req);
    win_op = '0;
    case (winner)
      3'b001:  win_op = live_op;
      3'b010:  win_op = rec_op;
      3'b100:  win_op = song_op;
      default: win_op = '0;
    endcase
  end

  // Only a song tone can be cut short, and only by a live key.
  assign preempt = (PREEMPT != 0) && req[0] && grant[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ack_cnt     <= '0;
      snd_en      <= 1'b0;
      snd_octave  <= '0;
      snd_note    <= '0;
      snd_length  <= '0;
      grant       <= '0;
      done        <= '0;
      aborted     <= '0;
      timeout_err <= 1'b0;
    end else begin
      done    <= '0;
      aborted <= '0;
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            grant                              <= winner;
            {snd_octave, snd_note, snd_length} <= win_op;
            ack_cnt                            <= '0;
            state                              <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (preempt) begin
            snd_en  <= 1'b0;
            aborted <= grant;
            state   <= ABORT;
          end else if (!snd_over) begin
            snd_en  <= 1'b1;
            ack_cnt <= '0;
            state   <= PLAY;
          end else if (ack_cnt == CNT_W'(ACK_TIMEOUT)) begin
            snd_en      <= 1'b0;
            aborted     <= grant;
            timeout_err <= 1'b1;
            state       <= ABORT;
          end else begin
            snd_en  <= 1'b1;
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (preempt) begin
            snd_en  <= 1'b0;
            aborted <= grant;
            state   <= ABORT;
          end else if (snd_over) begin
            snd_en <= 1'b0;
            done   <= grant;
            state  <= DONE;
          end
        end
        DONE, ABORT: begin
          grant                              <= '0;
          {snd_octave, snd_note, snd_length} <= '0;
          state                              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
